aes_host_seq: RTL

AES_HOST_SEQ -- requirements
Module: aes_host_seq

---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_host_seq_if.sv | 30 +++
 rtl/aes_seq_wdog.sv | 44 ++++
 rtl/aes_host_seq.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aes_pkg
//  Description : Shared constants for the AES host sequencer: register map,
//                CTRL/STATUS bit positions, key-size codes, FSM state
//                encoding and watchdog limit.
//  Revision    : 1.0  initial release
// ============================================================================
package aes_pkg;

    // Word addresses
    localparam logic [5:0] ADDR_KEY_BASE = 6'h00;   // 0x00-0x0F key words
    localparam logic [5:0] ADDR_DIN_BASE = 6'h10;   // 0x10-0x17 data-in words
    localparam logic [5:0] ADDR_RES_BASE = 6'h18;   // 0x18-0x1F result words
    localparam logic [5:0] ADDR_CTRL     = 6'h20;
    localparam logic [5:0] ADDR_STATUS   = 6'h21;

    // CTRL bit positions
    localparam int CTRL_START  = 0;
    localparam int CTRL_DEC    = 1;
    localparam int CTRL_SIZE   = 2;   // two bits, [3:2]
    localparam int CTRL_IRQ_EN = 4;

    // STATUS bit positions
    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVR  = 2;
    localparam int ST_TMO  = 3;

    // Key-size codes
    localparam logic [1:0] SIZE_128 = 2'd0;
    localparam logic [1:0] SIZE_192 = 2'd1;
    localparam logic [1:0] SIZE_256 = 2'd2;

    // Watchdog terminal count
    localparam logic [7:0] WDOG_LIMIT = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/aes_host_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_host_seq_if
//  Description : CPU register bus of the AES host sequencer.
//                bus_we_i    write strobe (one cycle per write)
//                bus_re_i    read strobe
//                bus_addr_i  6-bit word address
//                bus_wdata_i 16-bit write data
//                bus_rdata_o 16-bit registered read data
//                Modports: master (CPU side), slave (sequencer side).
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_host_seq_if;
    logic        bus_we_i;
    logic        bus_re_i;
    logic [5:0]  bus_addr_i;
    logic [15:0] bus_wdata_i;
    logic [15:0] bus_rdata_o;

    modport master (
        output bus_we_i, bus_re_i, bus_addr_i, bus_wdata_i,
        input  bus_rdata_o
    );

    modport slave (
        input  bus_we_i, bus_re_i, bus_addr_i, bus_wdata_i,
        output bus_rdata_o
    );
endinterface
`default_nettype wire

// File: rtl/aes_seq_wdog.sv
`default_nettype none
// ============================================================================
//  Module      : aes_seq_wdog
//  Description : 8-bit watchdog for the AES sequencer. Counts while enabled,
//                zeroes on clear, and flags expire on the cycle whose edge
//                brings the count to WDOG_LIMIT, i.e. WDOG_LIMIT cycles after
//                the enable first rises from a cleared count.
//                Ports: clk, rst_n, en_i, clr_i, expire_o.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_seq_wdog
    import aes_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic en_i,
    input  wire logic clr_i,
    output logic      expire_o
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 8'd0;
        end else if (en_i && (cnt_q != WDOG_LIMIT)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == (WDOG_LIMIT - 8'd1));

endmodule
`default_nettype wire

// File: rtl/aes_host_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_host_seq
//  Description : CPU-facing register block and sequencer for an AES core.
//                Holds key / data-in / result words, launches the core with
//                a one-cycle load pulse and collects the result.
//                Ports: clk, rst_n (async active-low), bus (register bus,
//                slave modport), irq_o, aes_load_o, aes_key_o, aes_data_o,
//                aes_size_o, aes_dec_o, aes_data_i, aes_busy_i.
//                Optional macro AES_SEQ_TIMEOUT_EN adds a RUN watchdog.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_host_seq
    import aes_pkg::*;
(
    input  wire logic          clk,
    input  wire logic          rst_n,
    aes_host_seq_if.slave      bus,
    output logic               irq_o,
    output logic               aes_load_o,
    output logic [255:0]       aes_key_o,
    output logic [127:0]       aes_data_o,
    output logic [1:0]         aes_size_o,
    output logic               aes_dec_o,
    input  wire logic [127:0]  aes_data_i,
    input  wire logic          aes_busy_i
);

    state_t         state_q, state_d;
    logic [255:0]   key_q;
    logic [127:0]   din_q;
    logic [127:0]   res_q;
    logic           ctrl_dec_q;
    logic [1:0]     ctrl_size_q;
    logic           ctrl_irq_en_q;
    logic [1:0]     size_q;
    logic           dec_q;
    logic           done_q, ovr_q, tmo_q;
    logic [15:0]    rdata_q, rdata_d;

    logic w_busy, w_start, w_start_ok, w_key_wr, w_din_wr;
    logic w_ctrl_wr, w_stat_wr, w_ovr_set, w_capture, w_expire;
    logic w_unused_wdata;

    assign w_busy     = (state_q == S_LOAD) || (state_q == S_ARM) || (state_q == S_RUN);
    assign w_ctrl_wr  = bus.bus_we_i && (bus.bus_addr_i == ADDR_CTRL);
    assign w_stat_wr  = bus.bus_we_i && (bus.bus_addr_i == ADDR_STATUS);
    assign w_start    = w_ctrl_wr && bus.bus_wdata_i[CTRL_START];
    assign w_key_wr   = bus.bus_we_i && (bus.bus_addr_i[5:4] == ADDR_KEY_BASE[5:4]);
    assign w_din_wr   = bus.bus_we_i && (bus.bus_addr_i[5:3] == ADDR_DIN_BASE[5:3]);
    assign w_start_ok = w_start && !w_busy;
    assign w_ovr_set  = w_busy && (w_start || w_key_wr || w_din_wr);
    assign w_capture  = (state_q == S_RUN) && !aes_busy_i;
    assign w_unused_wdata = ^bus.bus_wdata_i[15:5];

`ifdef AES_SEQ_TIMEOUT_EN
    aes_seq_wdog u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     ((state_q == S_ARM) || (state_q == S_RUN)),
        .clr_i    (state_q == S_LOAD),
        .expire_o (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: state_d = w_start_ok ? S_LOAD : S_IDLE;
            S_LOAD:         state_d = S_ARM;
            S_ARM:          state_d = S_RUN;
            S_RUN: begin
                // A real completion wins over a same-cycle watchdog expiry.
                if (w_capture)      state_d = S_DONE;
                else if (w_expire)  state_d = S_IDLE;
            end
            default:        state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rdata_d = 16'h0000;
        if (bus.bus_re_i) begin
            if (bus.bus_addr_i[5:4] == ADDR_KEY_BASE[5:4])
                rdata_d = key_q[{bus.bus_addr_i[3:0], 4'h0} +: 16];
            else if (bus.bus_addr_i[5:3] == ADDR_DIN_BASE[5:3])
                rdata_d = din_q[{bus.bus_addr_i[2:0], 4'h0} +: 16];
            else if (bus.bus_addr_i[5:3] == ADDR_RES_BASE[5:3])
                rdata_d = res_q[{bus.bus_addr_i[2:0], 4'h0} +: 16];
            else if (bus.bus_addr_i == ADDR_CTRL)
                rdata_d = {11'h000, ctrl_irq_en_q, ctrl_size_q, ctrl_dec_q, 1'b0};
            else if (bus.bus_addr_i == ADDR_STATUS)
                rdata_d = {12'h000, tmo_q, ovr_q, done_q, w_busy};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= '0;
            din_q         <= '0;
            res_q         <= '0;
            ctrl_dec_q    <= 1'b0;
            ctrl_size_q   <= SIZE_128;
            ctrl_irq_en_q <= 1'b0;
            size_q        <= SIZE_128;
            dec_q         <= 1'b0;
            done_q        <= 1'b0;
            ovr_q         <= 1'b0;
            tmo_q         <= 1'b0;
            rdata_q       <= 16'h0000;
        end else begin
            rdata_q <= rdata_d;

            if (w_key_wr && !w_busy)
                key_q[{bus.bus_addr_i[3:0], 4'h0} +: 16] <= bus.bus_wdata_i;
            if (w_din_wr && !w_busy)
                din_q[{bus.bus_addr_i[2:0], 4'h0} +: 16] <= bus.bus_wdata_i;

            if (w_ctrl_wr) begin
                ctrl_dec_q    <= bus.bus_wdata_i[CTRL_DEC];
                ctrl_size_q   <= bus.bus_wdata_i[CTRL_SIZE +: 2];
                ctrl_irq_en_q <= bus.bus_wdata_i[CTRL_IRQ_EN];
            end
            // Core mode is taken from the very write that carries START.
            if (w_start_ok) begin
                dec_q  <= bus.bus_wdata_i[CTRL_DEC];
                size_q <= bus.bus_wdata_i[CTRL_SIZE +: 2];
            end

            if (w_capture)
                res_q <= aes_data_i;

            // Set has priority over a same-cycle write-1-to-clear.
            if (w_capture || w_expire)
                done_q <= 1'b1;
            else if (w_start_ok || (w_stat_wr && bus.bus_wdata_i[ST_DONE]))
                done_q <= 1'b0;

            if (w_ovr_set)
                ovr_q <= 1'b1;
            else if (w_stat_wr && bus.bus_wdata_i[ST_OVR])
                ovr_q <= 1'b0;

            if (w_expire && !w_capture)
                tmo_q <= 1'b1;
            else if (w_stat_wr && bus.bus_wdata_i[ST_TMO])
                tmo_q <= 1'b0;
        end
    end

    assign bus.bus_rdata_o = rdata_q;
    assign irq_o           = done_q && ctrl_irq_en_q;
    assign aes_load_o      = (state_q == S_LOAD);
    assign aes_key_o       = key_q;
    assign aes_data_o      = din_q;
    assign aes_size_o      = size_q;
    assign aes_dec_o       = dec_q;

endmodule
`default_nettype wire
